func_hdl_fork: RTL and testbench

- Output-side counterpart of the kernel-wrapper stream join.
- Takes the single-handshake TyBEC-style result stream (ivalid/iready, one packed vector) and fans it out to C_NUM_CHANNELS independent AXI4-Stream master channels.
- Each channel completes its own tvalid/tready handshake.
- Sits between the TyBEC main module's output and the SDx AXI stream/memory-mover channels, e.g. dual output buffers.

---
 rtl/func_hdl_fork_pkg.sv | 18 +
 rtl/func_hdl_fork_if.sv | 33 +++
 rtl/func_hdl_fork_fifo.sv | 63 ++++++
 rtl/func_hdl_fork.sv | 80 ++++++++
 tb/tb_func_hdl_fork.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/func_hdl_fork_pkg.sv
// func_hdl_fork shared types: beat width derived from TY_GVECT,
// the packed beat vector type and a pointer-width helper.
`ifndef TY_GVECT
`define TY_GVECT 16
`endif

package func_hdl_pkg;

    localparam int C_DATA_WIDTH_DEF = 32 * `TY_GVECT;

    typedef logic [C_DATA_WIDTH_DEF-1:0] vect_t;

    // Pointer width that never collapses to zero bits.
    function automatic int clog2_min1(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/func_hdl_fork_if.sv
// func_hdl_fork bus: single input beat handshake plus
// per-channel AXI4-Stream master outputs.
interface func_hdl_fork_if #(
    parameter int DW  = func_hdl_pkg::C_DATA_WIDTH_DEF,
    parameter int NCH = 2
);

    logic                    ivalid;
    logic [DW-1:0]           idata;
    logic                    iready;
    logic [NCH-1:0]          m_tvalid;
    logic [NCH-1:0][DW-1:0]  m_tdata;
    logic [NCH-1:0]          m_tready;

    modport slave (
        input  ivalid,
        input  idata,
        output iready,
        output m_tvalid,
        output m_tdata,
        input  m_tready
    );

    modport master (
        output ivalid,
        output idata,
        input  iready,
        input  m_tvalid,
        input  m_tdata,
        output m_tready
    );

endinterface

// File: rtl/func_hdl_fork_fifo.sv
// func_fork_fifo: one output channel of the fork; synchronous FIFO whose
// head is held in a register so tdata is glitch-free and AXI-stable.
module func_fork_fifo
    import func_hdl_pkg::*;
#(
    parameter  int DW    = 32,
    parameter  int DEPTH = 4,
    localparam int AW    = clog2_min1(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_ready,
    output logic          o_valid,
    output logic [DW-1:0] o_data,
    output logic [AW:0]   o_count_nxt
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [AW:0]   r_count;
    logic [DW-1:0] r_dout;

    logic          w_pop;
    logic [AW-1:0] w_rd_nxt;
    logic [AW:0]   w_cnt_pop;
    logic [AW:0]   w_cnt_nxt;

    assign w_pop     = (r_count != '0) && i_ready;
    assign w_rd_nxt  = r_rd_ptr + AW'(w_pop);
    assign w_cnt_pop = r_count - (AW+1)'(w_pop);
    assign w_cnt_nxt = w_cnt_pop + (AW+1)'(i_push);

    always_ff @(posedge clk) begin
        if (i_push)
            r_mem[r_wr_ptr] <= i_wdata;
    end

    // Head reloads only when it leaves or the FIFO was empty; a push
    // into an emptying FIFO forwards the written beat straight to the head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_dout   <= '0;
        end else begin
            if (i_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            r_rd_ptr <= w_rd_nxt;
            r_count  <= w_cnt_nxt;
            if ((w_pop || r_count == '0) && w_cnt_nxt != '0)
                r_dout <= (w_cnt_pop == '0) ? i_wdata : r_mem[w_rd_nxt];
        end
    end

    assign o_valid     = (r_count != '0);
    assign o_data      = r_dout;
    assign o_count_nxt = w_cnt_nxt;

endmodule

// File: rtl/func_hdl_fork.sv
// func_hdl_fork: fans one TyBEC result stream out to C_NUM_CHANNELS
// AXI4-Stream masters. Optional counters under `FORK_STATS_EN.
module func_hdl_fork
    import func_hdl_pkg::*;
#(
    parameter int C_DATA_WIDTH   = C_DATA_WIDTH_DEF,
    parameter int C_NUM_CHANNELS = 2,
    parameter int C_FIFO_DEPTH   = 4
) (
    input  logic             aclk,
    input  logic             areset_n,
    func_hdl_fork_if.slave   s
`ifdef FORK_STATS_EN
    ,
    output logic [31:0]      stat_beats_in,
    output logic [31:0]      stat_stall_cycles
`endif
);

    localparam int AW = clog2_min1(C_FIFO_DEPTH);

    logic        r_iready;
    logic        w_push;
    logic        w_room;
    logic [AW:0] w_cnt_nxt [C_NUM_CHANNELS];

    assign w_push   = s.ivalid && r_iready;
    assign s.iready = r_iready;

    for (genvar c = 0; c < C_NUM_CHANNELS; c++) begin : g_ch
        func_fork_fifo #(
            .DW    (C_DATA_WIDTH),
            .DEPTH (C_FIFO_DEPTH)
        ) u_fifo (
            .clk         (aclk),
            .rst_n       (areset_n),
            .i_push      (w_push),
            .i_wdata     (s.idata),
            .i_ready     (s.m_tready[c]),
            .o_valid     (s.m_tvalid[c]),
            .o_data      (s.m_tdata[c]),
            .o_count_nxt (w_cnt_nxt[c])
        );
    end

    // Accept next cycle only if every channel will still have a free slot.
    always_comb begin
        w_room = 1'b1;
        for (int c = 0; c < C_NUM_CHANNELS; c++) begin
            if (w_cnt_nxt[c] >= (AW+1)'(C_FIFO_DEPTH))
                w_room = 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n)
            r_iready <= 1'b0;
        else
            r_iready <= w_room;
    end

`ifdef FORK_STATS_EN
    logic [31:0] r_beats;
    logic [31:0] r_stalls;

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            r_beats  <= '0;
            r_stalls <= '0;
        end else begin
            r_beats  <= r_beats + 32'(w_push);
            r_stalls <= r_stalls + 32'(s.ivalid && !r_iready);
        end
    end

    assign stat_beats_in     = r_beats;
    assign stat_stall_cycles = r_stalls;
`endif

endmodule

// File: tb/tb_func_hdl_fork.sv
// tb_func_hdl_fork: directed and random traffic against a per-channel
// queue model of the fork; model tracks contents, not RTL state.
module tb_func_hdl_fork;
    import func_hdl_pkg::*;

    localparam int NCH   = 2;
    localparam int DEPTH = 4;
    localparam int DW    = C_DATA_WIDTH_DEF;

    logic clk = 1'b0;
    logic areset_n;

    always #5 clk = ~clk;

    func_hdl_fork_if #(.DW(DW), .NCH(NCH)) bus ();

`ifdef FORK_STATS_EN
    logic [31:0] stat_b;
    logic [31:0] stat_s;
`endif

    func_hdl_fork #(
        .C_DATA_WIDTH   (DW),
        .C_NUM_CHANNELS (NCH),
        .C_FIFO_DEPTH   (DEPTH)
    ) dut (
        .aclk     (clk),
        .areset_n (areset_n),
        .s        (bus)
`ifdef FORK_STATS_EN
        ,
        .stat_beats_in     (stat_b),
        .stat_stall_cycles (stat_s)
`endif
    );

    int errors = 0;
    int checks = 0;

    vect_t          q [NCH][$];
    vect_t          prev_data [NCH];
    logic [NCH-1:0] prev_stall;
    logic           exp_iready;
    logic           last_acc;
    int             n_emit [NCH];
    int             n_acc;
    int             k;
    int             budget;
    int             start_emit [NCH];

    task automatic chk(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic vect_t rnd_vect();
        vect_t v;
        for (int i = 0; i < DW / 32; i++)
            v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    task automatic clear_model();
        for (int c = 0; c < NCH; c++)
            q[c].delete();
        prev_stall = '0;
        exp_iready = 1'b0;
        last_acc   = 1'b0;
    endtask

    // One clock: compare at negedge, apply handshakes at posedge.
    task automatic cycle();
        logic           acc;
        logic [NCH-1:0] pop;
        logic           room;
        @(negedge clk);
        chk("iready", bus.iready, exp_iready);
        for (int c = 0; c < NCH; c++) begin
            chk("tvalid", bus.m_tvalid[c], q[c].size() != 0);
            if (q[c].size() != 0)
                chk("tdata", bus.m_tdata[c], q[c][0]);
            if (prev_stall[c]) begin
                chk("stable_v", bus.m_tvalid[c], 1'b1);
                chk("stable_d", bus.m_tdata[c], prev_data[c]);
            end
            prev_stall[c] = bus.m_tvalid[c] && !bus.m_tready[c];
            prev_data[c]  = bus.m_tdata[c];
            pop[c] = (q[c].size() != 0) && bus.m_tready[c];
        end
        acc = bus.ivalid && exp_iready;
        @(posedge clk);
        last_acc = acc;
        if (acc)
            n_acc++;
        room = 1'b1;
        for (int c = 0; c < NCH; c++) begin
            if (pop[c]) begin
                void'(q[c].pop_front());
                n_emit[c]++;
            end
            if (acc)
                q[c].push_back(bus.idata);
            if (q[c].size() >= DEPTH)
                room = 1'b0;
        end
        exp_iready = room;
        #1;
    endtask

    task automatic drain();
        int left;
        bus.ivalid   = 1'b0;
        bus.m_tready = '1;
        left = 1;
        for (int n = 0; n < 40 && left != 0; n++) begin
            cycle();
            left = 0;
            for (int c = 0; c < NCH; c++)
                left += q[c].size();
        end
        chk("drain_done", left, 0);
    endtask

    task automatic reset_mid();
        #2 areset_n = 1'b0;
        #1;
        chk("rst_tvalid", bus.m_tvalid, '0);
        chk("rst_iready", bus.iready, 1'b0);
        clear_model();
        bus.ivalid = 1'b0;
        @(posedge clk);
        #1 areset_n = 1'b1;
    endtask

    initial begin
        areset_n     = 1'b0;
        bus.ivalid   = 1'b0;
        bus.idata    = '0;
        bus.m_tready = '0;
        n_acc        = 0;
        for (int c = 0; c < NCH; c++)
            n_emit[c] = 0;
        clear_model();
        #1;
        chk("init_iready", bus.iready, 1'b0);
        chk("init_tvalid", bus.m_tvalid, '0);
        for (int c = 0; c < NCH; c++)
            chk("init_tdata", bus.m_tdata[c], '0);
        @(posedge clk);
        #1 areset_n = 1'b1;

        // Full-rate stream 0..15.
        bus.m_tready = '1;
        cycle();
        for (int i = 0; i < 16; i++) begin
            bus.ivalid = 1'b1;
            bus.idata  = vect_t'(i);
            cycle();
            chk("stream_acc", last_acc, 1'b1);
        end
        drain();

        // Channel 1 stalled: fills, blocks input, then releases.
        k = 0;
        bus.m_tready = 2'b01;
        bus.ivalid   = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.idata = vect_t'(k);
            cycle();
            if (last_acc)
                k++;
        end
        chk("bp_iready", bus.iready, 1'b0);
        bus.idata    = vect_t'(k);
        bus.m_tready = 2'b11;
        cycle();
        chk("ready_after_pop", bus.iready, 1'b1);
        bus.m_tready = 2'b01;
        cycle();
        if (last_acc)
            k++;
        chk("refull_iready", bus.iready, 1'b0);
        bus.m_tready = 2'b11;
        for (int i = 0; i < 12; i++) begin
            bus.idata = vect_t'(k);
            cycle();
            if (last_acc)
                k++;
        end
        drain();

        // Random ready per channel over 1000 beats.
        for (int c = 0; c < NCH; c++)
            start_emit[c] = n_emit[c];
        k = 0;
        budget = 0;
        while (k < 1000 && budget < 20000) begin
            bus.ivalid   = ($urandom_range(0, 3) != 0);
            bus.idata    = rnd_vect();
            bus.m_tready = NCH'($urandom_range(0, (1 << NCH) - 1));
            cycle();
            if (last_acc)
                k++;
            budget++;
        end
        chk("rand_beats", k, 1000);
        drain();
        for (int c = 0; c < NCH; c++)
            chk("rand_complete", n_emit[c] - start_emit[c], k);

        // Reset with three beats buffered.
        bus.m_tready = '0;
        bus.ivalid   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.idata = rnd_vect();
            cycle();
        end
        bus.ivalid = 1'b0;
        reset_mid();
        bus.m_tready = '1;
        for (int i = 0; i < 4; i++)
            cycle();
        chk("post_rst_iready", bus.iready, 1'b1);
        chk("post_rst_tvalid", bus.m_tvalid, '0);

        // 10 accepted beats and 5 backpressured cycles.
        bus.m_tready = '0;
        bus.ivalid   = 1'b1;
        for (int i = 0; i < 9; i++) begin
            bus.idata = rnd_vect();
            cycle();
        end
        bus.ivalid   = 1'b0;
        bus.m_tready = '1;
        for (int i = 0; i < 4; i++)
            cycle();
        bus.ivalid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.idata = rnd_vect();
            cycle();
        end
        bus.ivalid = 1'b0;
`ifdef FORK_STATS_EN
        chk("stat_beats", stat_b, 32'd10);
        chk("stat_stalls", stat_s, 32'd5);
`endif
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
